// File: rtl/tgl_pkg.sv
// Shared types and constants for the tgl_debounce input conditioner.
// Build option TGL_DEBOUNCE_SYNC_EN is consumed by tgl_debounce_bit.
package tgl_pkg;

  // Default number of consecutive stable samples to accept a level change.
  localparam int unsigned DebounceDefault = 4;

  typedef enum logic [1:0] {
    StStableLow  = 2'd0,
    StWaitHigh   = 2'd1,
    StStableHigh = 2'd2,
    StWaitLow    = 2'd3
  } tgl_state_e;

  // Counter must hold 0..Debounce-1; never narrower than one bit.
  function automatic int unsigned cnt_width(input int unsigned debounce);
    if (debounce <= 2) begin
      return 1;
    end
    return $clog2(debounce);
  endfunction

endpackage

// File: rtl/tgl_debounce_bit.sv
// One debounce channel: optional 2-flop sync (TGL_DEBOUNCE_SYNC_EN), qualification FSM,
// saturating-free counter and registered toggle pulse / level / enable copy.
module tgl_debounce_bit
  import tgl_pkg::*;
#(
  parameter int unsigned Debounce = DebounceDefault
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic raw_i,
  input  logic e_i,
  output logic t_o,
  output logic eo_o,
  output logic level_o,
  output logic busy_o
);

  localparam int unsigned CntW = cnt_width(Debounce);
  localparam logic [CntW-1:0] CntMax = CntW'(Debounce - 1);

  logic s;

`ifdef TGL_DEBOUNCE_SYNC_EN
  logic [1:0] sync_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sync_q <= 2'b00;
    end else begin
      sync_q <= {sync_q[0], raw_i};
    end
  end

  assign s = sync_q[1];
`else
  assign s = raw_i;
`endif

  tgl_state_e      state_q;
  logic [CntW-1:0] cnt_q;
  logic            t_q;
  logic            eo_q;
  logic            level_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= StStableLow;
      cnt_q   <= '0;
      t_q     <= 1'b0;
      eo_q    <= 1'b0;
      level_q <= 1'b0;
    end else begin
      // Pulse is one cycle wide; only the rising-edge acceptance re-asserts it.
      t_q  <= 1'b0;
      eo_q <= e_i;
      unique case (state_q)
        StStableLow: begin
          if (s) begin
            state_q <= StWaitHigh;
            cnt_q   <= CntW'(1);
          end else begin
            cnt_q <= '0;
          end
        end
        StWaitHigh: begin
          if (!s) begin
            state_q <= StStableLow;
            cnt_q   <= '0;
          end else if (cnt_q == CntMax) begin
            state_q <= StStableHigh;
            cnt_q   <= '0;
            level_q <= 1'b1;
            t_q     <= e_i;
          end else begin
            cnt_q <= cnt_q + CntW'(1);
          end
        end
        StStableHigh: begin
          if (!s) begin
            state_q <= StWaitLow;
            cnt_q   <= CntW'(1);
          end else begin
            cnt_q <= '0;
          end
        end
        StWaitLow: begin
          if (s) begin
            state_q <= StStableHigh;
            cnt_q   <= '0;
          end else if (cnt_q == CntMax) begin
            state_q <= StStableLow;
            cnt_q   <= '0;
            level_q <= 1'b0;
          end else begin
            cnt_q <= cnt_q + CntW'(1);
          end
        end
      endcase
    end
  end

  assign t_o     = t_q;
  assign eo_o    = eo_q;
  assign level_o = level_q;
  assign busy_o  = (state_q == StWaitHigh) || (state_q == StWaitLow);

endmodule

// File: rtl/tgl_debounce.sv
// Multi-channel debouncer producing toggle pulses for a downstream toggle latch.
// Define TGL_DEBOUNCE_SYNC_EN to insert a 2-flop synchronizer per channel.
module tgl_debounce
  import tgl_pkg::*;
#(
  parameter int unsigned Width    = 1,
  parameter int unsigned Debounce = DebounceDefault
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic [Width-1:0] raw_i,
  input  logic [Width-1:0] e_i,
  output logic [Width-1:0] t_o,
  output logic [Width-1:0] eo_o,
  output logic [Width-1:0] level_o,
  output logic [Width-1:0] busy_o,
  output logic [Width-1:0] return_o
);

  for (genvar i = 0; i < Width; i++) begin : g_chan
    tgl_debounce_bit #(
      .Debounce(Debounce)
    ) u_bit (
      .clk_i  (clk_i),
      .rst_ni (rst_ni),
      .raw_i  (raw_i[i]),
      .e_i    (e_i[i]),
      .t_o    (t_o[i]),
      .eo_o   (eo_o[i]),
      .level_o(level_o[i]),
      .busy_o (busy_o[i])
    );
  end

  assign return_o = t_o;

endmodule

// File: doc/tgl_debounce.md
# tgl_debounce

Per-bit input conditioner that sits directly upstream of the toggle-latch primitive. It turns raw, bouncy level inputs such as buttons or external strobes into clean, single-cycle toggle pulses on `_T`, plus a debounced level on `_level`. `_T` is wired straight to the toggle element's `_T` input; the gate-enable output `_Eo` drives its `_E`. Each bit is filtered independently by a small FSM and counter.

## Interface
- `WIDTH`, default 1: number of independent channels.
- `DEBOUNCE`, default 4: consecutive stable samples required to accept a level change. Legal range 2..65535.
- `_clock`, in, 1: single clock; all state changes on its rising edge.
- `_reset`, in, 1: reset, asynchronous and active-low.
- `_raw`, in, WIDTH: raw asynchronous level inputs.
- `_E`, in, WIDTH: per-bit pulse enable.
- `_T`, out, WIDTH: registered one-cycle toggle pulse per accepted rising edge.
- `_Eo`, out, WIDTH: registered copy of `_E`, aligned with `_T`.
- `_level`, out, WIDTH: registered debounced level.
- `_busy`, out, WIDTH: bit is in a WAIT state (a change is being qualified).
- `_return`, out, WIDTH: equals `_T`.

## Operation
- Sample `s[i]` is the synchronized input when the sync stage is compiled in, otherwise `_raw[i]` directly.
- **Per-bit FSM states:** STABLE_LOW, WAIT_HIGH, STABLE_HIGH, WAIT_LOW. Counter width is clog2(DEBOUNCE).
- **STABLE_LOW**
  - `s`=1: go to WAIT_HIGH, cnt=1.
  - Otherwise hold, cnt=0.
- **WAIT_HIGH**
  - `s`=0: go back to STABLE_LOW, cnt=0. The glitch is rejected with no output change.
  - `s`=1 and cnt==DEBOUNCE-1: go to STABLE_HIGH, `_level`←1, `_T`←`_E` for one cycle, cnt=0.
  - Otherwise cnt+1.
- **STABLE_HIGH / WAIT_LOW:** mirror image of the above. Acceptance sets `_level`←0. No `_T` pulse on falling edges.
- **Pulse suppression:** `_T[i]` is the AND of the acceptance event and `_E[i]` sampled on the same edge. Suppressed pulses are dropped, never queued. The FSM and `_level` track regardless of `_E`.
- `_busy` is high exactly in WAIT_HIGH and WAIT_LOW.
- Channels never interact; simultaneous edges on several bits pulse in the same cycle.

## Timing
- **Reset values:** asynchronous assertion forces all outputs to 0, every state to STABLE_LOW, cnt=0 and sync flops to 0. This holds even mid-qualification.
- After reset deassertion, a bit that is already high qualifies as a normal rising edge.
- **Latency, sync stage out:** `_raw` first sampled high at edge k and held gives `_T` high for exactly the cycle after edge k+DEBOUNCE-1. That is DEBOUNCE edges including the first sample.
- **Latency, sync stage in:** add 2 edges.
- **Minimum spacing:** consecutive `_T` pulses on one bit are at least 2·DEBOUNCE cycles apart, because a low must be qualified in between.
- A raw pulse shorter than DEBOUNCE samples never changes `_level`.
- The counter never wraps; its maximum value is DEBOUNCE-1.

## Configuration
- Macro: `TGL_DEBOUNCE_SYNC_EN`.
- **Defined:** a two-flop synchronizer per bit feeds the FSM. Latency is DEBOUNCE+2 edges.
- **Undefined:** `_raw` feeds the FSM directly, for inputs already synchronous to `_clock`. Latency is DEBOUNCE edges.

## Structure
- **Package `tgl_pkg`:**
  - 2-bit state enum: STABLE_LOW=0, WAIT_HIGH=1, STABLE_HIGH=2, WAIT_LOW=3.
  - Counter-width helper function.
  - Default DEBOUNCE constant.
- **Sub-module `tgl_debounce_bit`:** one channel, containing the optional sync stage, FSM, counter and pulse register.
- **Top level:** generate-loops WIDTH instances and drives `_return`.

## Test plan
All scenarios use WIDTH=2 and DEBOUNCE=4, sync stage out.
1. **Clean rising edge:** reset, `_E`=2'b11, `_raw`[0] 0→1 sampled at edge 10 and held. Required: `_T`=2'b01 for the single cycle after edge 13, `_level`[0]=1 from then on, `_busy`[0] high after edges 10–12.
2. **Glitch rejection:** `_raw`[1] high for 3 cycles, then low. Required: `_T`[1] and `_level`[1] stay 0; `_busy`[1] returns to 0.
3. **Falling edge:** `_raw`[0] 1→0 held. Required: `_level`[0]→0 after 4 edges; no `_T` pulse.
4. **Enable masking:** `_E`=2'b00 during an accepted rising edge on bit 0. Required: `_level`[0]=1 and `_T` stays 0; re-enabling `_E` later produces no late pulse.
5. **Reset mid-qualification:** assert `_reset` low with cnt=2 in WAIT_HIGH. Required: all outputs 0 immediately, without waiting for a clock edge; with `_raw` still high, `_T` fires 4 edges after deassertion.
6. **Sync build:** define `TGL_DEBOUNCE_SYNC_EN` and repeat scenario 1. Required: the `_T` pulse arrives 2 cycles later, after edge 15.
